// File: rtl/my_lsu.sv
// Load/store unit: decodes memory control bits, runs a req/ack word-bus transaction and stalls the core until it completes.
// Optional feature: define LSU_TIMEOUT_EN to abort BUSY accesses after TIMEOUT_CYCLES cycles without ack.
module my_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_fault,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic        r_busReq;
    logic        r_busWe;
    logic [31:0] r_busAddr;
    logic [31:0] r_busWdata;
    logic [3:0]  r_busBe;
    logic [1:0]  r_offset;
    logic [2:0]  r_funct3;
    logic [31:0] r_rdata;

    logic        w_req;
    logic        w_loadOk;
    logic        w_storeOk;
    logic        w_legal;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdataRep;
    logic        w_start;
    logic        w_badAccess;
    logic        w_ackSeen;
    logic        w_expire;
    logic        w_timedOut;
    logic [31:0] w_shifted;
    logic [31:0] w_loadData;

    assign w_req     = i_mem_read | i_mem_write;
    assign w_ackSeen = i_bus_ack & r_busReq;

    always_comb begin
        w_loadOk     = 1'b0;
        w_storeOk    = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdataRep   = i_wdata;
        case (i_funct3)
            3'b000, 3'b001, 3'b010: begin
                w_loadOk  = 1'b1;
                w_storeOk = 1'b1;
            end
            3'b100, 3'b101: w_loadOk = 1'b1;
            default: ;
        endcase
        // funct3[1:0] encodes the access size for every legal load and store
        case (i_funct3[1:0])
            2'b00: begin
                w_be       = 4'b0001 << i_addr[1:0];
                w_wdataRep = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_misaligned = i_addr[0];
                w_be         = 4'b0011 << i_addr[1:0];
                w_wdataRep   = {2{i_wdata[15:0]}};
            end
            2'b10: w_misaligned = |i_addr[1:0];
            default: ;
        endcase
    end

    assign w_legal = !(i_mem_read && i_mem_write) && (i_mem_read ? w_loadOk : w_storeOk);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_waitCnt;
    logic             r_timedOut;

    assign w_expire   = (r_state == BUSY) && !w_ackSeen && (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_timedOut = r_timedOut;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_waitCnt  <= '0;
            r_timedOut <= 1'b0;
        end else begin
            r_timedOut <= w_expire;
            if (w_start) begin
                r_waitCnt <= '0;
            end else if (r_state == BUSY) begin
                r_waitCnt <= r_waitCnt + CNT_W'(1);
            end
        end
    end
`else
    // Without the timeout, BUSY waits for ack forever and never faults late
    assign w_expire   = 1'b0;
    assign w_timedOut = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        o_stall     = 1'b0;
        w_start     = 1'b0;
        w_badAccess = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_legal && !w_misaligned) begin
                        w_start     = 1'b1;
                        o_stall     = 1'b1;
                        w_stateNext = BUSY;
                    end else begin
                        w_badAccess = 1'b1;
                    end
                end
            end
            BUSY: begin
                o_stall = 1'b1;
                if (w_ackSeen || w_expire) begin
                    w_stateNext = DONE;
                end
            end
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        w_shifted  = i_bus_rdata >> {r_offset, 3'b000};
        w_loadData = w_shifted;
        case (r_funct3)
            3'b000:  w_loadData = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_loadData = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_loadData = {24'b0, w_shifted[7:0]};
            3'b101:  w_loadData = {16'b0, w_shifted[15:0]};
            default: w_loadData = w_shifted;
        endcase
    end

    // Bus fields are captured once on entry to BUSY and held until the next access
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busReq   <= 1'b0;
            r_busWe    <= 1'b0;
            r_busAddr  <= '0;
            r_busWdata <= '0;
            r_busBe    <= '0;
            r_offset   <= '0;
            r_funct3   <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_start) begin
                r_busReq   <= 1'b1;
                r_busWe    <= i_mem_write;
                r_busAddr  <= {i_addr[31:2], 2'b00};
                r_busWdata <= w_wdataRep;
                r_busBe    <= w_be;
                r_offset   <= i_addr[1:0];
                r_funct3   <= i_funct3;
            end else if ((r_state == BUSY) && (w_ackSeen || w_expire)) begin
                r_busReq <= 1'b0;
                if (!r_busWe) begin
                    r_rdata <= w_ackSeen ? w_loadData : 32'b0;
                end
            end
        end
    end

    assign o_rdata     = w_badAccess ? 32'b0 : r_rdata;
    assign o_fault     = w_badAccess | ((r_state == DONE) && w_timedOut);
    assign o_bus_req   = r_busReq;
    assign o_bus_we    = r_busWe;
    assign o_bus_addr  = r_busAddr;
    assign o_bus_wdata = r_busWdata;
    assign o_bus_be    = r_busBe;

endmodule
